risc_control_fsm: RTL and testbench
===================================

Name: risc_control_fsm

Overview:
- Multi-cycle control unit sitting directly upstream of the ALU in the RISC_1 datapath.
- Fetches an instruction word, decodes it, and drives the 7-bit ALU operation code, operand select and immediate.
- Sequences the register-file, memory and hi/lo write enables.
- Holds a flag register loaded from the ALU's zero/carry/sign/overflow outputs; branches resolve against that register.

Parameters:
PC_W, 10, width of the word-addressed program counter
MULT_LAT, 2, EXEC cycles for multu/mult (legal range 1..15)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE
imem_valid  in  1  instruction word present on imem_data
imem_data  in  32  fetched instruction
dmem_ready  in  1  data memory completed the current request
zflag, carryflag, signflag, overflowflag  in  1 each  ALU flags, valid during EXEC
imem_req  out  1  fetch request
pc  out  PC_W  current instruction address
rs_addr, rt_addr  out  5 each  register-file read addresses (IR[25:21], IR[20:16])
aluOp  out  7  ALU operation code
alu_src_imm  out  1  1 selects imm_ext as ALU input2
imm_ext  out  32  sign-extended IR[15:0]
reg_write  out  1  register-file write strobe; write address is rs_addr
hilo_write  out  1  hi/lo register write strobe
mem_read, mem_write  out  1 each  data memory request, held until dmem_ready
halted, illegal  out  1 each  sticky status

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, IR=0, flag register=0, counter=0.
  - All strobes, requests and status outputs are 0; aluOp=0.
  - A reset mid-operation aborts immediately with no partial write.
- Opcode IR[31:26]:
  - 000000 R-ALU: aluOp=IR[6:0]; input2 from rt.
  - 000001 addi: aluOp=0000100, imm.
  - 000010 compi: aluOp=0000101, imm.
  - 000100 lw, 000101 sw: aluOp=0000000 (add), imm.
  - 001000 bz, 001001 bnz, 001010 bcy, 001011 bneg, 001100 b.
  - 111111 halt.
  - Any other opcode is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ILLEGAL.
- IDLE: start=1 -> FETCH; otherwise hold.
- FETCH:
  - imem_req=1 while in this state.
  - On imem_valid: IR<=imem_data, pc<=pc+1 (wraps modulo 2^PC_W), -> DECODE.
  - imem_valid outside FETCH is ignored.
- DECODE (1 cycle):
  - halt -> HALT; illegal -> ILLEGAL (illegal=1); branch -> EXEC; all others -> EXEC.
- EXEC:
  - aluOp, alu_src_imm and imm_ext are held stable for the whole state.
  - Duration: 1 cycle, or MULT_LAT cycles when the R-ALU aluOp is 0000001 or 0000010 (4-bit down-counter).
  - Last cycle, ALU-class and lw/sw: the flag register latches {z,c,s,v}.
  - Last cycle, branches: the flag register is unchanged; if the condition is met (bz: Z=1; bnz: Z=0; bcy: C=1; bneg: S=1; b: always), pc<=pc+imm_ext[PC_W-1:0] (pc already incremented, wraps).
  - Next state: branch -> FETCH; lw -> MEM with mem_read; sw -> MEM with mem_write; mult/multu -> WB with hilo_write path; other ALU-class -> WB.
- MEM:
  - The request is held while dmem_ready=0 (no timeout).
  - dmem_ready=1: request drops the next cycle; lw -> WB, sw -> FETCH.
  - dmem_ready asserted in the same cycle as entry completes in 1 cycle.
- WB (1 cycle):
  - reg_write=1, or hilo_write=1 instead for mult/multu, never both. -> FETCH.
- HALT, ILLEGAL:
  - Absorbing states; halted or illegal held at 1.
  - start is ignored; only reset exits.
- All outputs are registered or decoded from state and IR only; no combinational path from ALU flags to outputs.

Decomposition:
- risc_pkg: opcode constants, aluOp codes (ADD=0000000, MULTU=0000001, MULT=0000010, COMP=0000011, ADDI=0000100, COMPI=0000101, AND=0010000, SHLL=0100000, SHRL=0100001), state encoding.
- One sub-module, risc_branch_cond: combinational condition evaluation from opcode and flag register.

Test Plan:
- Reset then start; imem_data=R-ALU add rs=1 rt=2 -> FETCH, DECODE, EXEC, WB.
  - reg_write=1 for exactly 1 cycle in WB; aluOp=0000000; pc=1.
- R-ALU mult with MULT_LAT=3 -> EXEC lasts 3 cycles; hilo_write=1 and reg_write=0 in WB.
- addi imm=0xFFFF -> imm_ext=0xFFFFFFFF, alu_src_imm=1; zflag=1 captured; following bz imm=-2 -> pc decrements to target; bnz -> pc unchanged.
- lw with dmem_ready delayed 4 cycles -> mem_read held 4 cycles, then WB.
  - sw with immediate dmem_ready -> MEM lasts 1 cycle, straight to FETCH with no reg_write.
- Opcode 010101 -> illegal=1 and stuck.
  - halt opcode -> halted=1; start pulses ignored.
  - rst_n low mid-MEM -> all outputs 0 asynchronously, pc=RESET_PC.
- pc=2^PC_W-1 fetch -> pc wraps to 0; imem_valid low for 5 cycles -> imem_req held, no state change.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings for the RISC_1 control unit: opcodes, ALU operation codes,
// FSM states, the flag-register layout and the instruction classifier.
package risc_pkg;

  localparam logic [5:0] OP_RALU  = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_COMPI = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_BZ    = 6'b001000;
  localparam logic [5:0] OP_BNZ   = 6'b001001;
  localparam logic [5:0] OP_BCY   = 6'b001010;
  localparam logic [5:0] OP_BNEG  = 6'b001011;
  localparam logic [5:0] OP_B     = 6'b001100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [6:0] ALU_ADD   = 7'b0000000;
  localparam logic [6:0] ALU_MULTU = 7'b0000001;
  localparam logic [6:0] ALU_MULT  = 7'b0000010;
  localparam logic [6:0] ALU_COMP  = 7'b0000011;
  localparam logic [6:0] ALU_ADDI  = 7'b0000100;
  localparam logic [6:0] ALU_COMPI = 7'b0000101;
  localparam logic [6:0] ALU_AND   = 7'b0010000;
  localparam logic [6:0] ALU_SHLL  = 7'b0100000;
  localparam logic [6:0] ALU_SHRL  = 7'b0100001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BRANCH,
    CLS_HALT,
    CLS_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic z;
    logic c;
    logic s;
    logic v;
  } flags_t;

  function automatic iclass_t classify(input logic [5:0] op);
    iclass_t cls;
    case (op)
      OP_RALU, OP_ADDI, OP_COMPI:            cls = CLS_ALU;
      OP_LW:                                 cls = CLS_LW;
      OP_SW:                                 cls = CLS_SW;
      OP_BZ, OP_BNZ, OP_BCY, OP_BNEG, OP_B:  cls = CLS_BRANCH;
      OP_HALT:                               cls = CLS_HALT;
      default:                               cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic is_mult_op(input logic [6:0] alu_op);
    return (alu_op == ALU_MULTU) || (alu_op == ALU_MULT);
  endfunction

endpackage

// File: rtl/risc_branch_cond.sv
// Branch condition evaluation against the registered ALU flags; non-branch
// opcodes never report taken.
module risc_branch_cond
  import risc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  flags_t     i_flags,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BZ:   o_taken = i_flags.z;
      OP_BNZ:  o_taken = ~i_flags.z;
      OP_BCY:  o_taken = i_flags.c;
      OP_BNEG: o_taken = i_flags.s;
      OP_B:    o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/risc_control_fsm.sv
// Multi-cycle fetch/decode/execute controller driving the RISC_1 ALU, register
// file, hi/lo registers and data memory strobes.
module risc_control_fsm
  import risc_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int MULT_LAT = 2,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  input  logic            dmem_ready,
  input  logic            zflag,
  input  logic            carryflag,
  input  logic            signflag,
  input  logic            overflowflag,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  output logic [6:0]      aluOp,
  output logic            alu_src_imm,
  output logic [31:0]     imm_ext,
  output logic            reg_write,
  output logic            hilo_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            halted,
  output logic            illegal
);

  localparam logic [PC_W-1:0] L_RESET_PC = PC_W'(RESET_PC);
  localparam logic [3:0]      L_MULT_CNT = 4'(MULT_LAT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_pc;
  flags_t          r_flags;
  logic [3:0]      r_cnt;

  logic [5:0]      w_opcode;
  iclass_t         w_class;
  logic            w_is_mult;
  logic            w_exec_last;
  logic            w_taken;
  logic [31:0]     w_imm_ext;

  assign w_opcode    = r_ir[31:26];
  assign w_class     = classify(w_opcode);
  assign w_is_mult   = (w_class == CLS_ALU) && (w_opcode == OP_RALU) && is_mult_op(r_ir[6:0]);
  assign w_exec_last = (r_cnt == 4'd0);
  assign w_imm_ext   = {{16{r_ir[15]}}, r_ir[15:0]};

  risc_branch_cond u_branch_cond (
    .i_opcode (w_opcode),
    .i_flags  (r_flags),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (imem_valid) w_next = S_DECODE;
      S_DECODE: begin
        case (w_class)
          CLS_HALT:    w_next = S_HALT;
          CLS_ILLEGAL: w_next = S_ILLEGAL;
          default:     w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (w_exec_last) begin
          case (w_class)
            CLS_BRANCH:     w_next = S_FETCH;
            CLS_LW, CLS_SW: w_next = S_MEM;
            default:        w_next = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (dmem_ready) w_next = (w_class == CLS_LW) ? S_WB : S_FETCH;
      end
      S_WB:      w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_IDLE;
    endcase
  end

  // Instruction, PC, EXEC-length counter and flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= '0;
      r_pc    <= L_RESET_PC;
      r_flags <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir <= imem_data;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_DECODE: r_cnt <= w_is_mult ? L_MULT_CNT : 4'd0;
        S_EXEC: begin
          if (!w_exec_last) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (w_class == CLS_BRANCH) begin
            if (w_taken) r_pc <= r_pc + w_imm_ext[PC_W-1:0];
          end else begin
            r_flags <= '{z: zflag, c: carryflag, s: signflag, v: overflowflag};
          end
        end
        default: ;
      endcase
    end
  end

  // Branches still present an add/immediate to the ALU; its result is unused.
  always_comb begin
    aluOp       = ALU_ADD;
    alu_src_imm = 1'b0;
    case (w_opcode)
      OP_RALU:  aluOp = r_ir[6:0];
      OP_ADDI:  begin aluOp = ALU_ADDI;  alu_src_imm = 1'b1; end
      OP_COMPI: begin aluOp = ALU_COMPI; alu_src_imm = 1'b1; end
      OP_LW, OP_SW, OP_BZ, OP_BNZ, OP_BCY, OP_BNEG, OP_B: begin
        aluOp       = ALU_ADD;
        alu_src_imm = 1'b1;
      end
      default: begin
        aluOp       = ALU_ADD;
        alu_src_imm = 1'b0;
      end
    endcase
  end

  assign pc         = r_pc;
  assign rs_addr    = r_ir[25:21];
  assign rt_addr    = r_ir[20:16];
  assign imm_ext    = w_imm_ext;
  assign imem_req   = (r_state == S_FETCH);
  assign reg_write  = (r_state == S_WB) && !w_is_mult;
  assign hilo_write = (r_state == S_WB) &&  w_is_mult;
  assign mem_read   = (r_state == S_MEM) && (w_class == CLS_LW);
  assign mem_write  = (r_state == S_MEM) && (w_class == CLS_SW);
  assign halted     = (r_state == S_HALT);
  assign illegal    = (r_state == S_ILLEGAL);

endmodule

// File: tb/tb_risc_control_fsm.sv
// Directed-vector bench for risc_control_fsm with MULT_LAT=3, PC_W=10.
module tb_risc_control_fsm;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            imem_valid;
  logic [31:0]     imem_data;
  logic            dmem_ready;
  logic            zflag, carryflag, signflag, overflowflag;
  logic            imem_req;
  logic [PC_W-1:0] pc;
  logic [4:0]      rs_addr, rt_addr;
  logic [6:0]      aluOp;
  logic            alu_src_imm;
  logic [31:0]     imm_ext;
  logic            reg_write, hilo_write, mem_read, mem_write, halted, illegal;

  int errors = 0;
  int checks = 0;

  risc_control_fsm #(.PC_W(PC_W), .MULT_LAT(3), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_valid(imem_valid), .imem_data(imem_data), .dmem_ready(dmem_ready),
    .zflag(zflag), .carryflag(carryflag), .signflag(signflag), .overflowflag(overflowflag),
    .imem_req(imem_req), .pc(pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .aluOp(aluOp), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
    .reg_write(reg_write), .hilo_write(hilo_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic fetch(input logic [31:0] word);
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; imem_valid = 0; imem_data = '0; dmem_ready = 0;
    zflag = 0; carryflag = 0; signflag = 0; overflowflag = 0;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    checks++; if (aluOp !== 7'd0) begin errors++; $display("FAIL reset_aluop: got %b want 0", aluOp); end
    checks++;
    if ({imem_req, reg_write, hilo_write, mem_read, mem_write, halted, illegal, alu_src_imm} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000000",
               {imem_req, reg_write, hilo_write, mem_read, mem_write, halted, illegal, alu_src_imm});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_hold: imem_req got %b want 0", imem_req); end
  endtask

  task automatic test_r_add();
    pulse_start();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL add_fetch_req: got %b want 1", imem_req); end
    fetch(32'h0022_0000);
    checks++; if (pc !== 10'd1) begin errors++; $display("FAIL add_pc: got %0d want 1", pc); end
    @(negedge clk);
    checks++;
    if ({aluOp, rs_addr, rt_addr, alu_src_imm, reg_write} !== {7'd0, 5'd1, 5'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: aluOp=%b rs=%0d rt=%0d imm=%b rw=%b want 0000000/1/2/0/0",
               aluOp, rs_addr, rt_addr, alu_src_imm, reg_write);
    end
    @(negedge clk);
    checks++; if ({reg_write, hilo_write} !== 2'b10) begin errors++; $display("FAIL add_wb: rw/hilo got %b want 10", {reg_write, hilo_write}); end
    @(negedge clk);
    checks++; if ({reg_write, imem_req} !== 2'b01) begin errors++; $display("FAIL add_wb_1cycle: rw/req got %b want 01", {reg_write, imem_req}); end
  endtask

  task automatic test_mult();
    fetch(32'h0022_0002);
    @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = 32'hFC00_0000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({aluOp, hilo_write, reg_write, imem_req} !== {7'd2, 3'b000}) begin
        errors++;
        $display("FAIL mult_exec%0d: aluOp=%b hilo/rw/req=%b want 0000010/000",
                 i, aluOp, {hilo_write, reg_write, imem_req});
      end
      @(negedge clk);
    end
    imem_valid = 1'b0;
    checks++; if ({hilo_write, reg_write} !== 2'b10) begin errors++; $display("FAIL mult_wb: hilo/rw got %b want 10", {hilo_write, reg_write}); end
    @(negedge clk);
    checks++;
    if ({hilo_write, imem_req, pc} !== {2'b01, 10'd2}) begin
      errors++;
      $display("FAIL mult_done: hilo=%b req=%b pc=%0d want 0/1/2", hilo_write, imem_req, pc);
    end
  endtask

  task automatic test_addi_branch();
    fetch(32'h0460_FFFF);
    @(negedge clk);
    checks++;
    if ({imm_ext, alu_src_imm, aluOp} !== {32'hFFFF_FFFF, 1'b1, 7'b0000100}) begin
      errors++;
      $display("FAIL addi_exec: imm_ext=%h src=%b aluOp=%b want ffffffff/1/0000100", imm_ext, alu_src_imm, aluOp);
    end
    zflag = 1'b1;
    @(negedge clk);
    zflag = 1'b0;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL addi_wb: rw got %b want 1", reg_write); end
    @(negedge clk);
    fetch(32'h2000_FFFE);
    checks++; if (pc !== 10'd4) begin errors++; $display("FAIL bz_pc_inc: got %0d want 4", pc); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, pc} !== {1'b1, 10'd2}) begin
      errors++;
      $display("FAIL bz_taken: req=%b pc=%0d want 1/2", imem_req, pc);
    end
    fetch(32'h2400_FFFE);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, pc} !== {1'b1, 10'd3}) begin
      errors++;
      $display("FAIL bnz_not_taken: req=%b pc=%0d want 1/3", imem_req, pc);
    end
  endtask

  task automatic test_lw();
    fetch(32'h1080_0010);
    @(negedge clk);
    checks++;
    if ({aluOp, alu_src_imm, imm_ext} !== {7'd0, 1'b1, 32'h0000_0010}) begin
      errors++;
      $display("FAIL lw_exec: aluOp=%b src=%b imm=%h want 0000000/1/00000010", aluOp, alu_src_imm, imm_ext);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_read, mem_write, reg_write} !== 3'b100) begin
        errors++;
        $display("FAIL lw_mem%0d: rd/wr/rw got %b want 100", i, {mem_read, mem_write, reg_write});
      end
      if (i == 3) dmem_ready = 1'b1;
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    checks++; if ({mem_read, reg_write} !== 2'b01) begin errors++; $display("FAIL lw_wb: rd/rw got %b want 01", {mem_read, reg_write}); end
    @(negedge clk);
  endtask

  task automatic test_sw();
    fetch(32'h1480_0010);
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++; if ({mem_write, mem_read} !== 2'b10) begin errors++; $display("FAIL sw_mem: wr/rd got %b want 10", {mem_write, mem_read}); end
    @(negedge clk);
    dmem_ready = 1'b0;
    checks++;
    if ({mem_write, reg_write, imem_req, pc} !== {3'b001, 10'd5}) begin
      errors++;
      $display("FAIL sw_done: wr/rw/req=%b pc=%0d want 001/5", {mem_write, reg_write, imem_req}, pc);
    end
  endtask

  task automatic test_pc_wrap();
    fetch(32'h3000_03F9);
    @(negedge clk);
    @(negedge clk);
    checks++; if (pc !== 10'd1023) begin errors++; $display("FAIL b_target: got %0d want 1023", pc); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({imem_req, pc} !== {1'b1, 10'd1023}) begin
        errors++;
        $display("FAIL fetch_stall%0d: req=%b pc=%0d want 1/1023", i, imem_req, pc);
      end
      @(negedge clk);
    end
    fetch(32'h0022_0000);
    checks++; if ({pc, imem_req} !== {10'd0, 1'b0}) begin errors++; $display("FAIL pc_wrap: pc=%0d req=%b want 0/0", pc, imem_req); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    fetch(32'h1080_0010);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_pre_mem: rd got %b want 1", mem_read); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read, reg_write, imem_req, pc} !== {3'b000, 10'd0}) begin
      errors++;
      $display("FAIL rst_async: rd/rw/req=%b pc=%0d want 000/0", {mem_read, reg_write, imem_req}, pc);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_read, reg_write, imem_req} !== 3'b000) begin
      errors++;
      $display("FAIL rst_idle: rd/rw/req=%b want 000", {mem_read, reg_write, imem_req});
    end
  endtask

  task automatic test_illegal();
    pulse_start();
    fetch(32'h5400_0000);
    @(negedge clk);
    checks++; if ({illegal, halted} !== 2'b10) begin errors++; $display("FAIL illegal_set: ill/halt got %b want 10", {illegal, halted}); end
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if ({illegal, imem_req} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_sticky: ill/req got %b want 10", {illegal, imem_req});
    end
  endtask

  task automatic test_halt();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", illegal); end
    pulse_start();
    fetch(32'hFC00_0000);
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if ({halted, imem_req, illegal} !== 3'b100) begin
      errors++;
      $display("FAIL halt_sticky: halt/req/ill got %b want 100", {halted, imem_req, illegal});
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_mult();
    test_addi_branch();
    test_lw();
    test_sw();
    test_pc_wrap();
    test_reset_mid_mem();
    test_illegal();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
